// File: rtl/axi4_burst_responder_pkg.sv
// Shared types and response codes for the AXI4 burst-memory responder.
package axi4_burst_responder_pkg;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  localparam logic AXI_RESP_OKAY = 1'b0;
  localparam logic AXI_RESP_ERR  = 1'b1;

endpackage

// File: rtl/axi4_resp_sram.sv
// 1R1W byte-lane SRAM: read-first on same-word collisions, one-cycle registered read.
module axi4_resp_sram #(
  parameter int DW    = 32,
  parameter int DEPTH = 16384,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DW-1:0]     rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DW-1:0]     wr_data,
  input  logic [DW/8-1:0]   wr_strb
);

  // One array per byte lane keeps each lane a plain read-first block RAM.
  for (genvar gi = 0; gi < DW / 8; gi++) begin : g_lane
    logic [7:0] mem_reg [DEPTH];
    logic [7:0] q_reg;

    always_ff @(posedge clk) begin
      if (wr_en && wr_strb[gi]) begin
        mem_reg[wr_idx] <= wr_data[gi*8 +: 8];
      end
      if (rst) begin
        q_reg <= '0;
      end else if (rd_en) begin
        q_reg <= mem_reg[rd_idx];
      end
    end

    assign rd_data[gi*8 +: 8] = q_reg;
  end

endmodule

// File: rtl/axi4_burst_responder.sv
// AXI4 slave responder: INCR read and write bursts served from an on-chip byte-enabled SRAM.
module axi4_burst_responder
  import axi4_burst_responder_pkg::*;
#(
  parameter int AXI_LEN_W = 8,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MEM_BYTE  = 64 * 1024,
  parameter int RD_LAT    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 axi4_ar_ready,
  input  logic [AW-1:0]        axi4_ar_addr,
  input  logic                 axi4_ar_valid,
  input  logic [AXI_LEN_W-1:0] axi4_ar_len,
  output logic [DW-1:0]        axi4_r_data,
  output logic                 axi4_r_valid,
  output logic                 axi4_r_last,
  input  logic                 axi4_r_ready,
  output logic                 axi4_aw_ready,
  input  logic [AW-1:0]        axi4_aw_addr,
  input  logic                 axi4_aw_valid,
  input  logic [AXI_LEN_W-1:0] axi4_aw_len,
  input  logic [DW-1:0]        axi4_w_data,
  input  logic [DW/8-1:0]      axi4_w_strb,
  input  logic                 axi4_w_valid,
  input  logic                 axi4_w_last,
  output logic                 axi4_w_ready,
  output logic                 axi4_b_valid,
  output logic                 axi4_b_resp,
  input  logic                 axi4_b_ready
);

  localparam int BYTES = DW / 8;
  localparam int DEPTH = MEM_BYTE / BYTES;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(BYTES);
  localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  rd_state_t              rd_state_reg;
  logic [IDX_W-1:0]       r_addr_reg;
  logic [AXI_LEN_W-1:0]   r_len_reg, r_beat_reg;
  logic [LAT_W-1:0]       lat_cnt_reg;
  logic                   ar_ready_reg, r_valid_reg, r_last_reg;

  wr_state_t              wr_state_reg;
  logic [IDX_W-1:0]       w_addr_reg;
  logic [AXI_LEN_W-1:0]   w_len_reg, w_beat_reg;
  logic                   aw_ready_reg, w_ready_reg, b_valid_reg, b_resp_reg;

  logic                   r_fire, w_fire, w_end, sram_rd_en;
  logic [IDX_W-1:0]       sram_rd_idx;
  logic [DW-1:0]          sram_q;
  logic                   unused_addr_bits;

  assign r_fire = r_valid_reg & axi4_r_ready;
  assign w_fire = w_ready_reg & axi4_w_valid;
  assign w_end  = (w_beat_reg == w_len_reg);

  // The SRAM output register holds the presented beat; the next word is fetched only
  // when the current beat retires, so stalls keep r_data stable without extra storage.
  assign sram_rd_en  = ((rd_state_reg == R_WAIT) && (lat_cnt_reg == LAT_W'(RD_LAT))) ||
                       ((rd_state_reg == R_DATA) && r_fire && !r_last_reg);
  assign sram_rd_idx = (rd_state_reg == R_DATA) ? r_addr_reg + IDX_W'(1) : r_addr_reg;

  assign unused_addr_bits = ^{axi4_ar_addr, axi4_aw_addr};

  axi4_resp_sram #(.DW(DW), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_sram (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (sram_rd_en),
    .rd_idx  (sram_rd_idx),
    .rd_data (sram_q),
    .wr_en   (w_fire),
    .wr_idx  (w_addr_reg),
    .wr_data (axi4_w_data),
    .wr_strb (axi4_w_strb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_reg <= R_IDLE;
      r_addr_reg   <= '0;
      r_len_reg    <= '0;
      r_beat_reg   <= '0;
      lat_cnt_reg  <= '0;
      ar_ready_reg <= 1'b0;
      r_valid_reg  <= 1'b0;
      r_last_reg   <= 1'b0;
    end else begin
      case (rd_state_reg)
        R_IDLE: begin
          if (axi4_ar_valid && ar_ready_reg) begin
            r_addr_reg   <= axi4_ar_addr[OFF_W +: IDX_W];
            r_len_reg    <= axi4_ar_len;
            r_beat_reg   <= '0;
            lat_cnt_reg  <= '0;
            ar_ready_reg <= 1'b0;
            rd_state_reg <= R_WAIT;
          end else begin
            ar_ready_reg <= 1'b1;
          end
        end
        R_WAIT: begin
          if (lat_cnt_reg == LAT_W'(RD_LAT)) begin
            r_valid_reg  <= 1'b1;
            r_last_reg   <= (r_len_reg == '0);
            rd_state_reg <= R_DATA;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (r_last_reg) begin
              r_valid_reg  <= 1'b0;
              r_last_reg   <= 1'b0;
              ar_ready_reg <= 1'b1;
              rd_state_reg <= R_IDLE;
            end else begin
              r_addr_reg <= r_addr_reg + IDX_W'(1);
              r_beat_reg <= r_beat_reg + AXI_LEN_W'(1);
              r_last_reg <= ((r_beat_reg + AXI_LEN_W'(1)) == r_len_reg);
            end
          end
        end
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_reg <= W_IDLE;
      w_addr_reg   <= '0;
      w_len_reg    <= '0;
      w_beat_reg   <= '0;
      aw_ready_reg <= 1'b0;
      w_ready_reg  <= 1'b0;
      b_valid_reg  <= 1'b0;
      b_resp_reg   <= AXI_RESP_OKAY;
    end else begin
      case (wr_state_reg)
        W_IDLE: begin
          if (axi4_aw_valid && aw_ready_reg) begin
            w_addr_reg   <= axi4_aw_addr[OFF_W +: IDX_W];
            w_len_reg    <= axi4_aw_len;
            w_beat_reg   <= '0;
            b_resp_reg   <= AXI_RESP_OKAY;
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b1;
            wr_state_reg <= W_DATA;
          end else begin
            aw_ready_reg <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr_reg <= w_addr_reg + IDX_W'(1);
            w_beat_reg <= w_beat_reg + AXI_LEN_W'(1);
            // The burst closes on whichever comes first; any disagreement is an error.
            if (axi4_w_last || w_end) begin
              w_ready_reg  <= 1'b0;
              b_valid_reg  <= 1'b1;
              b_resp_reg   <= (axi4_w_last != w_end) ? AXI_RESP_ERR : AXI_RESP_OKAY;
              wr_state_reg <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi4_b_ready) begin
            b_valid_reg  <= 1'b0;
            b_resp_reg   <= AXI_RESP_OKAY;
            aw_ready_reg <= 1'b1;
            wr_state_reg <= W_IDLE;
          end
        end
        default: wr_state_reg <= W_IDLE;
      endcase
    end
  end

  assign axi4_ar_ready = ar_ready_reg;
  assign axi4_r_valid  = r_valid_reg;
  assign axi4_r_last   = r_last_reg;
  assign axi4_r_data   = sram_q;
  assign axi4_aw_ready = aw_ready_reg;
  assign axi4_w_ready  = w_ready_reg;
  assign axi4_b_valid  = b_valid_reg;
  assign axi4_b_resp   = b_resp_reg;

endmodule

// File: tb/tb_axi4_burst_responder.sv
// Bench for axi4_burst_responder: directed burst table, corner sequences and random bursts vs a byte-array model.
module tb_axi4_burst_responder;

  localparam int MEM_BYTE = 64 * 1024;
  localparam int RD_LAT   = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_ready, ar_valid, r_valid, r_last, r_ready;
  logic [31:0] ar_addr, r_data;
  logic [7:0]  ar_len, aw_len;
  logic        aw_ready, aw_valid, w_valid, w_last, w_ready, b_valid, b_resp, b_ready;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference memory: plain byte array plus a "has been written" flag per byte.
  logic [7:0] ref_mem   [MEM_BYTE];
  bit         ref_known [MEM_BYTE];

  always #5 clk = ~clk;

  axi4_burst_responder #(.AXI_LEN_W(8), .DW(32), .AW(32), .MEM_BYTE(MEM_BYTE), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .axi4_ar_ready(ar_ready), .axi4_ar_addr(ar_addr), .axi4_ar_valid(ar_valid), .axi4_ar_len(ar_len),
    .axi4_r_data(r_data), .axi4_r_valid(r_valid), .axi4_r_last(r_last), .axi4_r_ready(r_ready),
    .axi4_aw_ready(aw_ready), .axi4_aw_addr(aw_addr), .axi4_aw_valid(aw_valid), .axi4_aw_len(aw_len),
    .axi4_w_data(w_data), .axi4_w_strb(w_strb), .axi4_w_valid(w_valid), .axi4_w_last(w_last),
    .axi4_w_ready(w_ready), .axi4_b_valid(b_valid), .axi4_b_resp(b_resp), .axi4_b_ready(b_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: got no handshake within 64 cycles, expected one", name);
  endtask

  function automatic int word_base(input int addr);
    return (addr % MEM_BYTE) & ~3;
  endfunction

  function automatic logic [31:0] ref_data(input int addr);
    logic [31:0] d;
    for (int b = 0; b < 4; b++) d[b*8 +: 8] = ref_mem[word_base(addr) + b];
    return d;
  endfunction

  function automatic logic [31:0] ref_mask(input int addr);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = ref_known[word_base(addr) + b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic model_write(input int addr, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) begin
        ref_mem[word_base(addr) + b]   = d[b*8 +: 8];
        ref_known[word_base(addr) + b] = 1'b1;
      end
    end
  endtask

  task automatic aw_handshake(input int addr, input int len, output bit ok);
    bit r;
    ok = 1'b0;
    aw_addr = addr; aw_len = len[7:0]; aw_valid = 1'b1;
    for (int g = 0; g < 64; g++) begin
      r = aw_ready;
      step();
      if (r) begin ok = 1'b1; break; end
    end
    aw_valid = 1'b0;
    if (!ok) timeout_fail("aw_handshake");
  endtask

  task automatic ar_handshake(input int addr, input int len, output bit ok);
    bit r;
    ok = 1'b0;
    ar_addr = addr; ar_len = len[7:0]; ar_valid = 1'b1;
    for (int g = 0; g < 64; g++) begin
      r = ar_ready;
      step();
      if (r) begin ok = 1'b1; break; end
    end
    ar_valid = 1'b0;
    if (!ok) timeout_fail("ar_handshake");
  endtask

  // Presents beats 0..last_at (or 0..len when w_last is late/missing), then a stray beat that must be refused.
  task automatic axi_write(input int addr, input int len, input int last_at,
                           input logic [31:0] dq[$], input logic [3:0] sq[$],
                           input int gap_pct, output logic resp);
    int nb;
    bit ok, r;
    resp = 1'b0;
    nb = (last_at <= len) ? last_at + 1 : len + 1;
    aw_handshake(addr, len, ok);
    if (!ok) return;
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 99) < gap_pct) begin w_valid = 1'b0; step(); end
      w_valid = 1'b1; w_data = dq[i]; w_strb = sq[i]; w_last = (i == last_at);
      ok = 1'b0;
      for (int g = 0; g < 64; g++) begin
        r = w_ready;
        step();
        if (r) begin ok = 1'b1; break; end
      end
      if (!ok) begin timeout_fail("w_beat"); w_valid = 1'b0; return; end
      model_write(addr + 4 * i, dq[i], sq[i]);
    end
    w_data = 32'hDEAD_BEEF; w_strb = 4'hF; w_last = 1'b0;
    check("wr_w_ready_after_end", {31'b0, w_ready}, 32'd0);
    repeat ($urandom_range(0, 2)) step();
    check("wr_b_valid", {31'b0, b_valid}, 32'd1);
    b_ready = 1'b1;
    ok = 1'b0;
    for (int g = 0; g < 64; g++) begin
      r = b_valid; resp = b_resp;
      step();
      if (r) begin ok = 1'b1; break; end
    end
    b_ready = 1'b0; w_valid = 1'b0;
    if (!ok) timeout_fail("b_resp");
    $display("WR addr=%08h len=%0d beats=%0d resp=%0d", addr, len, nb, resp);
  endtask

  task automatic axi_read(input int addr, input int len, input int ready_pct,
                          input bit chk_timing, output logic [31:0] first_data);
    bit ok, stalled;
    int waited, beat, cycles, guard;
    logic [31:0] held_d, m;
    logic held_l;
    first_data = '0;
    r_ready = 1'b0;
    ar_handshake(addr, len, ok);
    if (!ok) return;
    waited = 0;
    while (!r_valid && waited < 64) begin step(); waited++; end
    if (!r_valid) begin timeout_fail("r_first"); return; end
    if (chk_timing) check("rd_first_latency", waited, 1 + RD_LAT);
    beat = 0; cycles = 0; guard = 0; stalled = 1'b0;
    while (beat <= len && guard < 64 * (len + 2)) begin
      r_ready = ($urandom_range(0, 99) < ready_pct);
      if (stalled && r_valid) begin
        check("rd_hold_data", r_data, held_d);
        check("rd_hold_last", {31'b0, r_last}, {31'b0, held_l});
      end
      if (r_valid && r_ready) begin
        if (beat == 0) first_data = r_data;
        m = ref_mask(addr + 4 * beat);
        if (m != 0) check($sformatf("rd_data_b%0d", beat), r_data & m, ref_data(addr + 4 * beat) & m);
        check($sformatf("rd_last_b%0d", beat), {31'b0, r_last}, {31'b0, beat == len});
        beat++;
        stalled = 1'b0;
      end else if (r_valid) begin
        held_d = r_data; held_l = r_last; stalled = 1'b1;
      end
      step();
      cycles++; guard++;
    end
    r_ready = 1'b0;
    if (beat <= len) begin timeout_fail("r_beats"); return; end
    check("rd_valid_after_last", {31'b0, r_valid}, 32'd0);
    if (chk_timing) check("rd_no_bubbles", cycles, len + 1);
    $display("RD addr=%08h len=%0d beats=%0d cycles=%0d", addr, len, beat, cycles);
  endtask

  typedef struct packed {
    int          addr;
    int          len;
    int          last_at;
    logic [31:0] data_base;
    logic [3:0]  strb;
    logic        exp_resp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] dq[$];
    logic [3:0]  sq[$];
    logic        resp;
    logic [31:0] fd;
    bit          ok;
    int          a, l, la;

    for (int i = 0; i < MEM_BYTE; i++) ref_known[i] = 1'b0;
    rst = 1'b1;
    ar_valid = 0; ar_addr = 0; ar_len = 0; r_ready = 0;
    aw_valid = 0; aw_addr = 0; aw_len = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    repeat (3) step();
    check("init_rst_outs", {25'b0, ar_ready, r_valid, r_last, aw_ready, w_ready, b_valid, b_resp}, 32'd0);
    rst = 1'b0;
    step();
    check("init_ar_ready", {31'b0, ar_ready}, 32'd1);
    check("init_aw_ready", {31'b0, aw_ready}, 32'd1);

    // addr, len, last_at, data_base, strb, expected b_resp
    vecs[0] = '{32'h100, 7, 7, 32'h0000_0000, 4'hF, 1'b0};
    vecs[1] = '{32'h200, 0, 0, 32'h1122_3344, 4'hF, 1'b0};
    vecs[2] = '{32'h200, 0, 0, 32'hAABB_CCDD, 4'h5, 1'b0};
    vecs[3] = '{MEM_BYTE - 8, 3, 3, 32'h5000_0000, 4'hF, 1'b0};
    vecs[4] = '{32'h300, 7, 7, 32'h3000_0000, 4'hF, 1'b0};
    vecs[5] = '{32'h300, 7, 3, 32'h3100_0000, 4'hF, 1'b1};
    vecs[6] = '{32'h340, 2, 9, 32'h3400_0000, 4'hF, 1'b1};

    for (int v = 0; v < 7; v++) begin
      dq = {}; sq = {};
      for (int i = 0; i <= vecs[v].len; i++) begin
        dq.push_back(vecs[v].data_base + i);
        sq.push_back(vecs[v].strb);
      end
      axi_write(vecs[v].addr, vecs[v].len, vecs[v].last_at, dq, sq, 0, resp);
      check($sformatf("vec%0d_bresp", v), {31'b0, resp}, {31'b0, vecs[v].exp_resp});
      axi_read(vecs[v].addr, vecs[v].len, 100, 1'b1, fd);
      if (v == 0) check("vec0_first_word", fd, 32'h0000_0000);
      if (v == 2) check("strb_merge_0x200", fd, 32'h11BB_33DD);
      if (v == 3) begin
        axi_read(0, 1, 100, 1'b1, fd);
        check("wrap_word0", fd, 32'h5000_0002);
      end
    end

    // Long read with a randomly stalling master.
    dq = {}; sq = {};
    for (int i = 0; i < 16; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    axi_write(32'h800, 15, 15, dq, sq, 30, resp);
    check("long_bresp", {31'b0, resp}, 32'd0);
    axi_read(32'h800, 15, 50, 1'b0, fd);

    // Read issued in the same cycle as a write to the same word returns the old word.
    dq = {32'hCAFE_0001}; sq = {4'hF};
    axi_write(32'h400, 0, 0, dq, sq, 0, resp);
    aw_handshake(32'h400, 0, ok);
    ar_handshake(32'h400, 0, ok);
    check("conc_w_ready", {31'b0, w_ready}, 32'd1);
    w_valid = 1'b1; w_data = 32'hCAFE_0002; w_strb = 4'hF; w_last = 1'b1;
    step();
    w_valid = 1'b0; w_last = 1'b0;
    check("conc_r_valid", {31'b0, r_valid}, 32'd1);
    check("conc_old_data", r_data, 32'hCAFE_0001);
    r_ready = 1'b1; step(); r_ready = 1'b0;
    check("conc_b_valid", {31'b0, b_valid}, 32'd1);
    check("conc_b_resp", {31'b0, b_resp}, 32'd0);
    b_ready = 1'b1; step(); b_ready = 1'b0;
    model_write(32'h400, 32'hCAFE_0002, 4'hF);
    $display("WR/RD collision addr=00000400 old=%08h", 32'hCAFE_0001);
    axi_read(32'h400, 0, 100, 1'b1, fd);
    check("conc_new_data", fd, 32'hCAFE_0002);

    // Reset in the middle of an open read burst and an open write burst.
    ar_handshake(32'h100, 7, ok);
    aw_handshake(32'h500, 3, ok);
    check("mid_r_valid", {31'b0, r_valid}, 32'd1);
    check("mid_w_ready", {31'b0, w_ready}, 32'd1);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_ctrl_outs", {25'b0, ar_ready, r_valid, r_last, aw_ready, w_ready, b_valid, b_resp}, 32'd0);
      check("rst_r_data", r_data, 32'd0);
    end
    rst = 1'b0;
    step();
    check("post_rst_ar_ready", {31'b0, ar_ready}, 32'd1);
    check("post_rst_aw_ready", {31'b0, aw_ready}, 32'd1);
    $display("RST mid-burst released");
    axi_read(32'h100, 7, 100, 1'b1, fd);

    // Random bursts, some near the top of memory so they wrap, some with misplaced w_last.
    for (int t = 0; t < 25; t++) begin
      a  = ($urandom_range(0, 1) == 1 ? MEM_BYTE - 32 : 32'h1000) + 4 * $urandom_range(0, 15);
      l  = $urandom_range(0, 15);
      la = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 17) : l;
      dq = {}; sq = {};
      for (int i = 0; i <= l; i++) begin dq.push_back($urandom); sq.push_back(4'($urandom)); end
      axi_write(a, l, la, dq, sq, 30, resp);
      check("rand_bresp", {31'b0, resp}, {31'b0, la != l});
      axi_read(a - 4 * $urandom_range(0, 2), $urandom_range(0, 15), 70, 1'b0, fd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running at 2ms, expected completion");
    $fatal(1);
  end

endmodule
